// File: rtl/pipe_seq_ctl.sv
// Pipeline sequencing control for the R/E/C stages: tracks E/C stage
// occupancy, decodes the optop and pc load enables and mux selects, and
// sequences the trap-frame build and the flush/optop-restore cycles.
module pipe_seq_ctl #(
    parameter int OPTOP_DELTA_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_l,
    input  logic                     inst_valid_r,
    input  logic [OPTOP_DELTA_W-1:0] optop_delta_r,
    input  logic [31:0]              optop_e,
    input  logic                     wr_optop_e,
    input  logic                     wr_optop_c,
    input  logic                     hold_r,
    input  logic                     hold_e,
    input  logic                     hold_c,
    input  logic                     trap_req,
    input  logic                     trap_done,
    input  logic                     flush_c,
    output logic [31:0]              optop_shft_r,
    output logic [3:0]               optop_sel_e,
    output logic [3:0]               optop_sel_c,
    output logic [2:0]               optop_enable,
    output logic [2:0]               pc_enable,
    output logic                     trap_in_progress,
    output logic                     valid_e,
    output logic                     valid_c
);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        TRAP    = 2'd2,
        RESTORE = 2'd3
    } state_t;

    // One-hot mux select codes: pipe, iu_data_e, shadow, reset constant.
    localparam logic [3:0] SEL_PIPE   = 4'b0001;
    localparam logic [3:0] SEL_DATA   = 4'b0010;
    localparam logic [3:0] SEL_SHADOW = 4'b0100;
    localparam logic [3:0] SEL_RESET  = 4'b1000;

    state_t state;

    // Next optop: the group pushes delta words, and the stack grows toward
    // lower addresses, so the word delta becomes a byte offset subtracted
    // from the current optop. Result is always word aligned.
    function automatic logic [31:0] next_optop(
        input logic [31:0]              optop,
        input logic [OPTOP_DELTA_W-1:0] delta
    );
        logic signed [31:0] delta_ext;
        logic signed [31:0] byte_delta;
        logic        [31:0] diff;
        delta_ext  = {{(32-OPTOP_DELTA_W){delta[OPTOP_DELTA_W-1]}}, delta};
        byte_delta = delta_ext <<< 2;
        diff       = optop - byte_delta;
        return {diff[31:2], 2'b00};
    endfunction

    assign optop_shft_r = next_optop(optop_e, optop_delta_r);

    // Sequencer state and stage occupancy; any trap/flush/reset empties E and C.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state   <= INIT;
            valid_e <= 1'b0;
            valid_c <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    state   <= RUN;
                    valid_e <= 1'b0;
                    valid_c <= 1'b0;
                end
                RUN: begin
                    if (trap_req && valid_c) begin
                        state   <= TRAP;
                        valid_e <= 1'b0;
                        valid_c <= 1'b0;
                    end else if (flush_c) begin
                        state   <= RESTORE;
                        valid_e <= 1'b0;
                        valid_c <= 1'b0;
                    end else begin
                        if (!hold_e) begin
                            valid_e <= inst_valid_r & ~hold_r;
                        end
                        // A held E with a free C lets a bubble into C.
                        if (!hold_c) begin
                            valid_c <= valid_e & ~hold_e;
                        end
                    end
                end
                TRAP: begin
                    valid_e <= 1'b0;
                    valid_c <= 1'b0;
                    if (trap_done) begin
                        state <= RUN;
                    end
                end
                RESTORE: begin
                    state   <= RUN;
                    valid_e <= 1'b0;
                    valid_c <= 1'b0;
                end
                default: begin
                    state   <= INIT;
                    valid_e <= 1'b0;
                    valid_c <= 1'b0;
                end
            endcase
        end
    end

    // Load enables and mux selects decoded from state, occupancy and stalls.
    always_comb begin
        optop_sel_e      = SEL_RESET;
        optop_sel_c      = SEL_RESET;
        optop_enable     = 3'b011;
        pc_enable        = 3'b000;
        trap_in_progress = 1'b0;
        case (state)
            INIT: begin
                optop_sel_e  = SEL_RESET;
                optop_sel_c  = SEL_RESET;
                optop_enable = 3'b011;
                pc_enable    = 3'b000;
            end
            RUN: begin
                pc_enable       = {valid_c & ~hold_c, ~hold_e, ~hold_r};
                optop_enable[0] = ~hold_e;
                // Arch optop and its shadow copy commit together with C.
                optop_enable[1] = valid_c & ~hold_c;
                optop_enable[2] = valid_c & ~hold_c;
                optop_sel_e     = (valid_e && wr_optop_e) ? SEL_DATA : SEL_PIPE;
                optop_sel_c     = wr_optop_c ? SEL_DATA : SEL_PIPE;
            end
            TRAP: begin
                trap_in_progress = 1'b1;
                pc_enable        = 3'b010;
                optop_sel_c      = SEL_PIPE;
                if (wr_optop_e) begin
                    optop_enable = 3'b001;
                    optop_sel_e  = SEL_DATA;
                end else begin
                    optop_enable = 3'b000;
                    optop_sel_e  = SEL_PIPE;
                end
            end
            RESTORE: begin
                optop_sel_e  = SEL_SHADOW;
                optop_sel_c  = SEL_SHADOW;
                optop_enable = 3'b011;
                pc_enable    = 3'b000;
            end
            default: begin
                optop_sel_e  = SEL_RESET;
                optop_sel_c  = SEL_RESET;
                optop_enable = 3'b011;
                pc_enable    = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_seq_ctl.sv
// Scoreboard bench for pipe_seq_ctl: a driver applies directed and random
// stimulus and queues the expected outputs from a behavioural model; a
// monitor pops and compares on every falling clock edge.
module tb_pipe_seq_ctl;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        inst_valid_r = 1'b0;
    logic [3:0]  optop_delta_r = '0;
    logic [31:0] optop_e = '0;
    logic        wr_optop_e = 1'b0;
    logic        wr_optop_c = 1'b0;
    logic        hold_r = 1'b0;
    logic        hold_e = 1'b0;
    logic        hold_c = 1'b0;
    logic        trap_req = 1'b0;
    logic        trap_done = 1'b0;
    logic        flush_c = 1'b0;
    logic [31:0] optop_shft_r;
    logic [3:0]  optop_sel_e;
    logic [3:0]  optop_sel_c;
    logic [2:0]  optop_enable;
    logic [2:0]  pc_enable;
    logic        trap_in_progress;
    logic        valid_e;
    logic        valid_c;

    pipe_seq_ctl #(.OPTOP_DELTA_W(4)) dut (
        .clk              (clk),
        .reset_l          (reset_l),
        .inst_valid_r     (inst_valid_r),
        .optop_delta_r    (optop_delta_r),
        .optop_e          (optop_e),
        .wr_optop_e       (wr_optop_e),
        .wr_optop_c       (wr_optop_c),
        .hold_r           (hold_r),
        .hold_e           (hold_e),
        .hold_c           (hold_c),
        .trap_req         (trap_req),
        .trap_done        (trap_done),
        .flush_c          (flush_c),
        .optop_shft_r     (optop_shft_r),
        .optop_sel_e      (optop_sel_e),
        .optop_sel_c      (optop_sel_c),
        .optop_enable     (optop_enable),
        .pc_enable        (pc_enable),
        .trap_in_progress (trap_in_progress),
        .valid_e          (valid_e),
        .valid_c          (valid_c)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        iv;
        logic [3:0]  dl;
        logic [31:0] op;
        logic        wre;
        logic        wrc;
        logic        hr;
        logic        he;
        logic        hc;
        logic        tr;
        logic        td;
        logic        fl;
    } stim_t;

    typedef struct packed {
        logic [31:0] shft;
        logic [3:0]  se;
        logic [3:0]  sc;
        logic [2:0]  oe;
        logic [2:0]  pe;
        logic        tip;
        logic        ve;
        logic        vc;
    } exp_t;

    localparam int MODE_INIT    = 0;
    localparam int MODE_RUN     = 1;
    localparam int MODE_TRAP    = 2;
    localparam int MODE_RESTORE = 3;

    // Behavioural model: what the sequencer is doing and which stages hold work.
    int  m_mode = MODE_INIT;
    bit  m_ve = 1'b0;
    bit  m_vc = 1'b0;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] ref_optop(input logic [31:0] op, input logic [3:0] dl);
        int     words;
        longint bytes_left;
        logic [31:0] r;
        words = int'(dl);
        if (words > 7) words = words - 16;
        bytes_left = longint'(op) - longint'(words) * 4;
        r = bytes_left[31:0];
        return r & 32'hFFFF_FFFC;
    endfunction

    function automatic exp_t expected(input stim_t s);
        exp_t e;
        e.shft = ref_optop(s.op, s.dl);
        e.ve   = m_ve;
        e.vc   = m_vc;
        e.tip  = (m_mode == MODE_TRAP);
        case (m_mode)
            MODE_RUN: begin
                e.pe = {m_vc && !s.hc, !s.he, !s.hr};
                e.oe = {m_vc && !s.hc, m_vc && !s.hc, !s.he};
                e.se = (m_ve && s.wre) ? 4'd2 : 4'd1;
                e.sc = s.wrc ? 4'd2 : 4'd1;
            end
            MODE_TRAP: begin
                e.pe = 3'b010;
                e.oe = s.wre ? 3'b001 : 3'b000;
                e.se = s.wre ? 4'd2 : 4'd1;
                e.sc = 4'd1;
            end
            MODE_RESTORE: begin
                e.pe = 3'b000;
                e.oe = 3'b011;
                e.se = 4'd4;
                e.sc = 4'd4;
            end
            default: begin
                e.pe = 3'b000;
                e.oe = 3'b011;
                e.se = 4'd8;
                e.sc = 4'd8;
            end
        endcase
        return e;
    endfunction

    task automatic advance(input stim_t s);
        bit nve;
        bit nvc;
        nve = 1'b0;
        nvc = 1'b0;
        case (m_mode)
            MODE_RUN: begin
                if (s.tr && m_vc) begin
                    m_mode = MODE_TRAP;
                end else if (s.fl) begin
                    m_mode = MODE_RESTORE;
                end else begin
                    nve = s.he ? m_ve : (s.iv && !s.hr);
                    nvc = s.hc ? m_vc : (m_ve && !s.he);
                end
            end
            MODE_TRAP: if (s.td) m_mode = MODE_RUN;
            default:   m_mode = MODE_RUN;
        endcase
        m_ve = nve;
        m_vc = nvc;
    endtask

    task automatic drive_and_expect(input stim_t s);
        inst_valid_r  = s.iv;
        optop_delta_r = s.dl;
        optop_e       = s.op;
        wr_optop_e    = s.wre;
        wr_optop_c    = s.wrc;
        hold_r        = s.hr;
        hold_e        = s.he;
        hold_c        = s.hc;
        trap_req      = s.tr;
        trap_done     = s.td;
        flush_c       = s.fl;
        exp_q.push_back(expected(s));
        advance(s);
    endtask

    task automatic apply(input stim_t s);
        @(posedge clk);
        #1;
        drive_and_expect(s);
    endtask

    function automatic stim_t mk(input logic iv, input logic he, input logic tr,
                                 input logic td, input logic fl);
        stim_t s;
        s    = '0;
        s.iv = iv;
        s.he = he;
        s.tr = tr;
        s.td = td;
        s.fl = fl;
        s.op = 32'h0000_2000;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.iv  = ($urandom_range(0, 9) < 7);
        s.dl  = 4'($urandom);
        s.op  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
        s.wre = $urandom_range(0, 1) == 1;
        s.wrc = $urandom_range(0, 1) == 1;
        s.hr  = ($urandom_range(0, 9) < 2);
        s.he  = ($urandom_range(0, 9) < 2);
        s.hc  = ($urandom_range(0, 9) < 2);
        s.tr  = ($urandom_range(0, 9) < 1);
        s.td  = ($urandom_range(0, 3) == 0);
        s.fl  = ($urandom_range(0, 19) < 1);
        return s;
    endfunction

    // Asynchronous reset in mid-cycle; the INIT cycle after release is queued.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_l = 1'b0;
        #1;
        check("reset trap_in_progress", trap_in_progress, 0);
        check("reset valid_e", valid_e, 0);
        check("reset valid_c", valid_c, 0);
        check("reset sel_e", optop_sel_e, 4'b1000);
        m_mode = MODE_INIT;
        m_ve   = 1'b0;
        m_vc   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_l = 1'b1;
        drive_and_expect(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    // Monitor: every cycle with a queued expectation is compared field by field.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("optop_shft_r", optop_shft_r, e.shft);
                check("optop_sel_e", optop_sel_e, e.se);
                check("optop_sel_c", optop_sel_c, e.sc);
                check("optop_enable", optop_enable, e.oe);
                check("pc_enable", pc_enable, e.pe);
                check("trap_in_progress", trap_in_progress, e.tip);
                check("valid_e", valid_e, e.ve);
                check("valid_c", valid_c, e.vc);
            end
        end
    end

    initial begin
        stim_t s;
        // Reset held from time zero.
        repeat (2) @(posedge clk);
        #1;
        check("por trap_in_progress", trap_in_progress, 0);
        check("por sel_c", optop_sel_c, 4'b1000);
        check("por optop_enable", optop_enable, 3'b011);
        reset_l = 1'b1;
        drive_and_expect(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Optop arithmetic corner vectors.
        s = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        s.op = 32'h0000_1000; s.dl = 4'd2;
        apply(s);
        #1 check("optop +2 words", optop_shft_r, 32'h0000_0FF8);
        s.dl = 4'hF;
        apply(s);
        #1 check("optop -1 word", optop_shft_r, 32'h0000_1004);
        s.op = 32'h0000_0000; s.dl = 4'd1;
        apply(s);
        #1 check("optop wrap", optop_shft_r, 32'hFFFF_FFFC);

        // Three groups with E held on the second: bubble reaches C.
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Fill C, then trap and flush together: trap wins; done after 5 cycles.
        repeat (3) apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
        repeat (5) apply(mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
        apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        repeat (2) apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Flush in RUN: one restore cycle.
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
        repeat (2) apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset while a trap frame is being built.
        repeat (3) apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
        repeat (2) apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        do_reset();
        repeat (2) apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset during a restore cycle.
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        do_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (i % 400 == 399) do_reset();
            else apply(rand_stim());
        end

        repeat (2) @(posedge clk);
        check("queue drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
